// File: rtl/uart_pkg.sv
// Shared constants and state types for the memory-mapped UART (uart_periph, uart_rx_core).
// Optional interrupt support is enabled with the UART_IRQ_EN macro in uart_periph.
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_RXDATA = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_BAUD   = 2'd3;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RX_VALID   = 1;
    localparam int ST_RX_OVERRUN = 2;
    localparam int ST_FRAME_ERR  = 3;
    localparam int ST_TX_DROP    = 4;

    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM, 8N1 deserialiser.
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | half a bit in, re-check the start bit (high = glitch)
//   RX_DATA  | sample 8 data bits LSB first, one per divisor period
//   RX_STOP  | sample the stop bit, report the byte, back to idle
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             byte_done_o,
    output logic [7:0]       byte_o,
    output logic             stop_err_o
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             rx_s;
    rx_state_t        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    assign rx_s   = sync_q[1];
    assign byte_o = shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_done_o = 1'b0;
        stop_err_o  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    div_d   = div_i;
                    cnt_d   = (div_i >> 1) - DIV_ONE;
                end
            end
            RX_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_ONE;
                end else if (rx_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DATA;
                    cnt_d   = div_q - DIV_ONE;
                    bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_ONE;
                end else begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = div_q - DIV_ONE;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_ONE;
                end else begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    byte_done_o = 1'b1;
                    stop_err_o  = ~rx_s;
                    state_d     = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: register file, W1C status, TX FSM; receive path in uart_rx_core.
// Define UART_IRQ_EN to add the irq output and interrupt enables in BAUD[17:16].
//   state    | meaning
//   TX_IDLE  | line high, a TXDATA write starts a frame
//   TX_START | drive start bit (0) for one divisor period
//   TX_DATA  | shift 8 data bits LSB first
//   TX_STOP  | drive stop bit (1), then back to idle
module uart_periph
    import uart_pkg::*;
#(
    parameter int DEFAULT_DIV = 868,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] uart_addr,
    input  logic [31:0] uart_write_data,
    input  logic        uart_wen,
    output logic [31:0] uart_read_data,
    output logic        uart_tx,
`ifdef UART_IRQ_EN
    output logic        irq,
`endif
    input  logic        uart_rx
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

    logic [1:0]       reg_sel;
    logic             wr_tx, wr_status, wr_baud;
    logic [4:0]       w1c;
    logic [DIV_W-1:0] baud_wr;

    logic [7:0]       txdata_q;
    logic [DIV_W-1:0] baud_q;
    logic             rx_valid_q, rx_overrun_q, frame_err_q, tx_drop_q;
    logic [7:0]       rx_byte_q;

    tx_state_t        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0] tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_q, tx_d;
    logic             tx_busy;

    logic             rx_done, rx_stop_err;
    logic [7:0]       rx_byte;

    logic             unused_bus;
    assign unused_bus = ^{uart_addr[63:4], uart_addr[1:0], uart_write_data};

    assign reg_sel   = uart_addr[3:2];
    assign wr_tx     = uart_wen && (reg_sel == REG_TXDATA);
    assign wr_status = uart_wen && (reg_sel == REG_STATUS);
    assign wr_baud   = uart_wen && (reg_sel == REG_BAUD);
    assign w1c       = wr_status ? uart_write_data[4:0] : 5'b0;
    assign baud_wr   = (uart_write_data[DIV_W-1:0] < DIV_MIN) ? DIV_MIN : uart_write_data[DIV_W-1:0];
    assign tx_busy   = (tx_state_q != TX_IDLE);
    assign uart_tx   = tx_q;

    uart_rx_core #(.DIV_W(DIV_W)) u_rx_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (uart_rx),
        .div_i       (baud_q),
        .byte_done_o (rx_done),
        .byte_o      (rx_byte),
        .stop_err_o  (rx_stop_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txdata_q     <= '0;
            baud_q       <= DIV_RST;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_drop_q    <= 1'b0;
            rx_byte_q    <= '0;
        end else begin
            if (wr_tx)   txdata_q <= uart_write_data[7:0];
            if (wr_baud) baud_q   <= baud_wr;
            // A completing byte beats a same-cycle clear of rx_valid and is then not an overrun.
            if (rx_done && (!rx_valid_q || w1c[ST_RX_VALID])) rx_byte_q <= rx_byte;
            rx_valid_q   <= rx_done | (rx_valid_q & ~w1c[ST_RX_VALID]);
            rx_overrun_q <= (rx_overrun_q & ~w1c[ST_RX_OVERRUN])
                          | (rx_done & rx_valid_q & ~w1c[ST_RX_VALID]);
            frame_err_q  <= (frame_err_q & ~w1c[ST_FRAME_ERR]) | (rx_done & rx_stop_err);
            tx_drop_q    <= (tx_drop_q & ~w1c[ST_TX_DROP]) | (wr_tx & tx_busy);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (wr_tx) begin
                    tx_state_d = TX_START;
                    tx_div_d   = baud_q;
                    tx_cnt_d   = baud_q - DIV_ONE;
                    tx_shift_d = uart_write_data[7:0];
                    tx_bit_d   = '0;
                end
            end
            TX_START: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - DIV_ONE;
                end else begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = tx_div_q - DIV_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - DIV_ONE;
                end else begin
                    tx_cnt_d = tx_div_q - DIV_ONE;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end
            end
            TX_STOP: begin
                if (tx_cnt_q != '0) tx_cnt_d   = tx_cnt_q - DIV_ONE;
                else                tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level is registered from the next state so uart_tx never glitches.
        case (tx_state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

`ifdef UART_IRQ_EN
    logic ie_rx_q, ie_tx_q, irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie_rx_q <= 1'b0;
            ie_tx_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            if (wr_baud) begin
                ie_rx_q <= uart_write_data[17];
                ie_tx_q <= uart_write_data[16];
            end
            irq_q <= (ie_rx_q & (rx_valid_q | rx_overrun_q | frame_err_q)) | (ie_tx_q & ~tx_busy);
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        uart_read_data = 32'h0;
        case (reg_sel)
            REG_TXDATA: uart_read_data = {24'h0, txdata_q};
            REG_RXDATA: uart_read_data = {23'h0, rx_valid_q, rx_byte_q};
            REG_STATUS: uart_read_data = {27'h0, tx_drop_q, frame_err_q, rx_overrun_q, rx_valid_q, tx_busy};
            REG_BAUD: begin
                uart_read_data[DIV_W-1:0] = baud_q;
`ifdef UART_IRQ_EN
                uart_read_data[17:16] = {ie_rx_q, ie_tx_q};
`endif
            end
            default: uart_read_data = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_uart_periph.sv
// Self-checking bench for uart_periph: directed register/frame cases plus randomized
// TX/RX frames against a register-level reference model.
module tb_uart_periph;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] uart_addr = '0;
    logic [31:0] uart_write_data = '0;
    logic        uart_wen = 1'b0;
    logic [31:0] uart_read_data;
    logic        uart_tx;
    logic        uart_rx = 1'b1;
`ifdef UART_IRQ_EN
    logic        irq;
`endif

    uart_periph dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uart_addr       (uart_addr),
        .uart_write_data (uart_write_data),
        .uart_wen        (uart_wen),
        .uart_read_data  (uart_read_data),
        .uart_tx         (uart_tx),
`ifdef UART_IRQ_EN
        .irq             (irq),
`endif
        .uart_rx         (uart_rx)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Reference model: architectural register contents.
    int         baud_m;
    logic [1:0] ie_m;
    logic [7:0] txd_m, rxb_m;
    logic       valid_m, ov_m, fe_m, drop_m, busy_m;

    task automatic model_reset();
        baud_m = 868; ie_m = 2'b00; txd_m = 8'h00; rxb_m = 8'h00;
        valid_m = 1'b0; ov_m = 1'b0; fe_m = 1'b0; drop_m = 1'b0; busy_m = 1'b0;
    endtask

    function automatic logic [31:0] exp_status();
        return {27'h0, drop_m, fe_m, ov_m, valid_m, busy_m};
    endfunction

    function automatic logic [31:0] exp_baud();
`ifdef UART_IRQ_EN
        return {14'h0, ie_m, 16'(baud_m)};
`else
        return 32'(baud_m);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] v);
        uart_addr = 64'h5000_0000 | {60'h0, r, 2'b00};
        #1;
        v = uart_read_data;
    endtask

    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        int b;
        uart_addr       = 64'h5000_0000 | {60'h0, r, 2'b00};
        uart_write_data = d;
        uart_wen        = 1'b1;
        tick();
        uart_wen        = 1'b0;
        case (r)
            REG_TXDATA: begin
                txd_m = d[7:0];
                if (busy_m) drop_m = 1'b1;
            end
            REG_STATUS: begin
                if (d[1]) valid_m = 1'b0;
                if (d[2]) ov_m    = 1'b0;
                if (d[3]) fe_m    = 1'b0;
                if (d[4]) drop_m  = 1'b0;
            end
            REG_BAUD: begin
                b = int'(d[15:0]);
                baud_m = (b < 2) ? 2 : b;
`ifdef UART_IRQ_EN
                ie_m = d[17:16];
`endif
            end
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] v;
        rd(REG_TXDATA, v); chk({tag, "_txdata"}, v, {24'h0, txd_m});
        rd(REG_RXDATA, v); chk({tag, "_rxdata"}, v, {23'h0, valid_m, rxb_m});
        rd(REG_STATUS, v); chk({tag, "_status"}, v, exp_status());
        rd(REG_BAUD, v);   chk({tag, "_baud"}, v, exp_baud());
    endtask

    // Send one byte; optionally at cycle index inject_k write TXDATA again (dropped),
    // at w1c_k clear tx_drop, at baud_k rewrite BAUD (takes effect next frame).
    task automatic tx_frame(input logic [7:0] b, input int inject_k, input int w1c_k,
                            input int baud_k, input logic [31:0] new_baud);
        int          div;
        logic [9:0]  fr;
        logic [31:0] v;
        div = baud_m;
        fr  = {1'b1, b, 1'b0};
        wr(REG_TXDATA, {24'h0, b});
        busy_m = 1'b1;
        for (int k = 0; k < 10 * div; k++) begin
            chk("tx_line", {31'h0, uart_tx}, {31'h0, fr[k / div]});
            rd(REG_STATUS, v);
            chk("tx_status", v, exp_status());
            if (k == inject_k)      wr(REG_TXDATA, $urandom_range(0, 255));
            else if (k == w1c_k)    wr(REG_STATUS, 32'h10);
            else if (k == baud_k)   wr(REG_BAUD, new_baud);
            else                    tick();
        end
        busy_m = 1'b0;
        chk("tx_line_idle", {31'h0, uart_tx}, 32'h1);
        check_regs("tx_end");
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        int div;
        div = baud_m;
        uart_rx = 1'b0;
        repeat (div) tick();
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (div) tick();
        end
        uart_rx = stop_bit;
        repeat (div) tick();
        uart_rx = 1'b1;
        repeat (4) tick();
        if (!valid_m) begin
            rxb_m   = b;
            valid_m = 1'b1;
        end else begin
            ov_m = 1'b1;
        end
        if (!stop_bit) fe_m = 1'b1;
        check_regs("rx");
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        rd(REG_TXDATA, v); chk("rst_txdata", v, 32'h0);
        rd(REG_RXDATA, v); chk("rst_rxdata", v, 32'h0);
        rd(REG_STATUS, v); chk("rst_status", v, 32'h0);
        rd(REG_BAUD, v);   chk("rst_baud", v, 32'd868);
        chk("rst_tx_line", {31'h0, uart_tx}, 32'h1);

        wr(REG_BAUD, 32'd1);          rd(REG_BAUD, v); chk("baud_clamp1", v, exp_baud());
        wr(REG_BAUD, 32'd0);          rd(REG_BAUD, v); chk("baud_clamp0", v, exp_baud());
        wr(REG_BAUD, 32'hFFFF_FFFF);  rd(REG_BAUD, v); chk("baud_wide", v, exp_baud());
        wr(REG_BAUD, 32'd8);

        tx_frame(8'hA5, -1, -1, -1, 32'h0);
        tx_frame(8'hA5, 20, 30, -1, 32'h0);
        wr(REG_STATUS, 32'h10);
        check_regs("after_drop");

        rx_frame(8'h5A, 1'b1);
        rd(REG_RXDATA, v); chk("rx_5a", v, 32'h15A);
        rx_frame(8'h77, 1'b1);
        rd(REG_RXDATA, v); chk("rx_overrun_keep", v, 32'h15A);
        rd(REG_STATUS, v); chk("rx_overrun_flag", v, 32'h06);
        wr(REG_RXDATA, 32'hFFFF_FFFF);
        check_regs("rxdata_wr_ignored");
        wr(REG_STATUS, 32'h06);
        rx_frame(8'h81, 1'b0);
        rd(REG_RXDATA, v); chk("rx_81", v, 32'h181);
        rd(REG_STATUS, v); chk("rx_frame_err", v, 32'h0A);
        uart_rx = 1'b0;
        repeat (3) tick();
        uart_rx = 1'b1;
        repeat (20) tick();
        check_regs("glitch");
        wr(REG_STATUS, 32'h1E);

        for (int it = 0; it < 10; it++) begin
            int op;
            wr(REG_BAUD, $urandom_range(8, 16));
            op = $urandom_range(0, 2);
            if (op == 0) begin
                int div;
                div = baud_m;
                tx_frame(8'($urandom_range(0, 255)),
                         $urandom_range(0, 1) ? int'($urandom_range(0, 10 * div - 1)) : -1,
                         -1,
                         $urandom_range(0, 1) ? int'($urandom_range(0, 10 * div - 1)) : -1,
                         $urandom_range(8, 16));
            end else if (op == 1) begin
                rx_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
            end else begin
                wr(REG_STATUS, $urandom_range(0, 31));
                check_regs("rand_w1c");
            end
        end

        wr(REG_BAUD, 32'd8);
        wr(REG_TXDATA, 32'hA5);
        busy_m = 1'b1;
        repeat (8 * 5 + 2) tick();
        chk("pre_reset_bit4", {31'h0, uart_tx}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_tx_line_async", {31'h0, uart_tx}, 32'h1);
        model_reset();
        rd(REG_STATUS, v); chk("reset_busy", v, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check_regs("post_reset");
        repeat (20) tick();
        chk("post_reset_line", {31'h0, uart_tx}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/uart_periph.md
Name: uart_periph

Overview:
Memory-mapped UART responder on the system bus UART port, occupying window 0x5000_0000–0x5000_000F. It sits at the far end of the uart_addr, uart_write_data, uart_wen and uart_read_data signals. It serialises bytes written by the CPU onto uart_tx (8N1) and deserialises uart_rx into a one-byte receive holding register. Reads are side-effect free, because the bus provides no read strobe; received data is consumed by a write-1-to-clear to STATUS.

Parameters:
DEFAULT_DIV, 868, reset value of the baud divisor (clk cycles per bit; 100 MHz / 115200).
DIV_W, 16, width of the baud divisor and bit counters.

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
uart_addr  input  64  bus address; only [3:2] decoded (bus guarantees window)
uart_write_data  input  32  write data
uart_wen  input  1  write strobe, one cycle per write
uart_read_data  output  32  combinational register readback selected by uart_addr[3:2]
uart_tx  output  1  serial out, idle high
uart_rx  input  1  serial in, asynchronous to clk

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA: W [7:0] starts a frame. R returns {24'b0, last byte written}.
  - 1 RXDATA: R returns {23'b0, rx_valid, rx_byte}. Writes are ignored.
  - 2 STATUS: R returns {27'b0, tx_drop, frame_err, rx_overrun, rx_valid, tx_busy}. W1C on bits [4:1]; bit0 is read-only.
  - 3 BAUD: R/W [DIV_W-1:0]. Written values <2 are stored as 2.
- Reset values: uart_tx=1, tx_busy=0, all STATUS flags 0, rx_byte=0, TXDATA=0, BAUD=DEFAULT_DIV.
- Writes take effect on the clk edge where uart_wen=1. uart_read_data is purely combinational, with no latency.
- TX FSM, states IDLE→START→DATA→STOP→IDLE:
  - The TXDATA write is accepted only in IDLE. tx_busy=1 from the next cycle.
  - The divisor is latched at frame start; BAUD writes mid-frame affect the next frame only.
  - Each state holds for div cycles. DATA sends 8 bits LSB first.
  - The frame lasts 10*div cycles, after which tx_busy falls.
  - A TXDATA write while busy is dropped (the frame in flight is unaffected) and sets tx_drop.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on synchronised falling edge.
  - START waits div/2 cycles and re-samples. If high, the event is a glitch: return to IDLE with no flags. If low, go to DATA.
  - DATA samples 8 bits at div intervals (mid-bit), LSB first.
  - STOP samples once at mid-bit, then returns to IDLE immediately (allows back-to-back frames).
- Byte completion, at the STOP sample:
  - If rx_valid=0: load rx_byte and set rx_valid.
  - If rx_valid=1: keep the old byte and set rx_overrun.
  - If the stop bit is 0: still load/overrun as above and also set frame_err.
- Simultaneous W1C of rx_valid and byte completion: completion wins. The new byte loads, rx_valid stays 1, and no overrun is flagged.
- Simultaneous W1C of a flag and a new set event for that flag: set wins.
- Reset mid-frame: uart_tx returns to 1 asynchronously, both FSMs go to IDLE, and the partial byte is discarded.

Optional Feature:
UART_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit).
  - BAUD bits [17:16] become ie_rx and ie_tx (R/W, reset 0).
  - irq = registered (ie_rx & (rx_valid|rx_overrun|frame_err)) | (ie_tx & ~tx_busy), one cycle latency.
- Undefined: no irq port, and BAUD reads [31:DIV_W] as 0.

Decomposition:
- Package uart_pkg holds:
  - register offset constants (REG_TXDATA=2'd0 … REG_BAUD=2'd3);
  - STATUS bit-position constants;
  - TX/RX state enum typedefs;
  - minimum divisor constant (2).
- One sub-module, uart_rx_core:
  - contains the synchroniser, RX FSM and bit counters;
  - outputs byte_done, byte, stop_err.
- The register file, W1C logic and TX FSM stay in uart_periph.

Test Plan:
- Reset, then read all four registers → 0, 0, 0, 868; uart_tx=1.
- Write BAUD=8, write TXDATA=0xA5 → uart_tx carries start 0, bits 1,0,1,0,0,1,0,1, stop 1, each 8 cycles; tx_busy high for exactly 80 cycles.
- During that frame, write TXDATA=0x3C → frame still sends 0xA5; STATUS=0x11; W1C 0x10 → STATUS=0x01.
- BAUD=8: drive 0x5A on uart_rx → RXDATA=0x15A, STATUS bit1=1; drive 0x77 without clearing → RXDATA still 0x15A, rx_overrun=1.
- Drive frame 0x81 with stop bit 0 → RXDATA=0x181, frame_err=1. Then a 3-cycle low glitch → no state change.
- Assert rst_n=0 mid-TX-frame (bit 4) → uart_tx=1 within the same cycle, tx_busy=0, BAUD=868 after release.
